// File: rtl/imuldiv_pkg.sv
// -----------------------------------------------------------------------------
// imuldiv_pkg
//   Shared widths and message types for the iterative multiplier/divider
//   requester side.
//   - OPND_W     : operand width (32)
//   - RESULT_W   : product width (64)
//   - CMD_MSG_W  : width of one buffered command {a, b} (64)
//   - TAG_W_DEF  : default result tag width (4)
// -----------------------------------------------------------------------------
package imuldiv_pkg;

   localparam int unsigned OPND_W    = 32;
   localparam int unsigned RESULT_W  = 64;
   localparam int unsigned CMD_MSG_W = 2 * OPND_W;
   localparam int unsigned TAG_W_DEF = 4;

   typedef logic [OPND_W-1:0]   opnd_t;
   typedef logic [RESULT_W-1:0] result_t;

   // One buffered multiply command; 'a' occupies the upper half.
   typedef struct packed {
      opnd_t a;
      opnd_t b;
   } cmd_msg_t;

endpackage : imuldiv_pkg

// File: rtl/imuldiv_queue.sv
// -----------------------------------------------------------------------------
// imuldiv_queue
//   Generic synchronous FIFO with registered storage. No enqueue bypass when
//   full and no flow-through when empty: data written on one edge is visible
//   on deq_data only after that edge. DEPTH need not be a power of two.
//
//   Ports
//     clk       in   clock, all state on rising edge
//     reset     in   asynchronous, active-low
//     enq_val   in   write request (ignored while full)
//     enq_data  in   WIDTH write data
//     full      out  no free entry
//     deq_en    in   pop request (ignored while empty)
//     deq_data  out  WIDTH head entry (stable until popped)
//     empty     out  no valid entry
// -----------------------------------------------------------------------------
module imuldiv_queue #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enq_val,
   input  logic [WIDTH-1:0] enq_data,
   output logic             full,
   input  logic             deq_en,
   output logic [WIDTH-1:0] deq_data,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   logic enq_fire;
   logic deq_fire;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign enq_fire = enq_val && !full;
   assign deq_fire = deq_en && !empty;
   assign deq_data = mem_q[rd_ptr_q];

   // NOTE: every variable gets its hold value first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (enq_fire) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (deq_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({enq_fire, deq_fire})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: non-blocking assignments for all flops so every register samples
   // the pre-edge value of its inputs regardless of block ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; validity is carried entirely by
   // the pointers and count, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (enq_fire) mem_q[wr_ptr_q] <= enq_data;
   end

endmodule : imuldiv_queue

// File: rtl/imuldiv_mul_requester.sv
// -----------------------------------------------------------------------------
// imuldiv_mul_requester
//   Initiator-side front end for the iterative multiplier. Operand pairs from
//   the pipeline are buffered in a command FIFO and issued on mulreq while
//   fewer than MAX_OUT requests are outstanding. Each issue pushes a sequential
//   tag into a tag FIFO; responses (which arrive in order) pick up the head
//   tag and land in a one-entry registered result stage. A watchdog flags a
//   multiplier that stops answering.
//
//   Ports
//     clk                 in   clock
//     reset               in   asynchronous, active-low
//     cmd_msg_a/_b        in   32-bit operands
//     cmd_val / cmd_rdy   in/out  command handshake (cmd_rdy = FIFO not full)
//     mulreq_msg_a/_b     out  operands of FIFO head
//     mulreq_val/_rdy     out/in  request handshake to multiplier
//     mulresp_msg_result  in   64-bit product
//     mulresp_val/_rdy    in/out  response handshake from multiplier
//     res_msg_result      out  registered product
//     res_tag             out  TAG_W tag of that product
//     res_val / res_rdy   out/in  result handshake to consumer
//     timeout_err         out  sticky watchdog flag
// -----------------------------------------------------------------------------
module imuldiv_mul_requester
   import imuldiv_pkg::*;
#(
   parameter int unsigned CMD_DEPTH = 4,
   parameter int unsigned MAX_OUT   = 2,
   parameter int unsigned TIMEOUT   = 64,
   parameter int unsigned TAG_W     = TAG_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   // command side
   input  logic [OPND_W-1:0]   cmd_msg_a,
   input  logic [OPND_W-1:0]   cmd_msg_b,
   input  logic                cmd_val,
   output logic                cmd_rdy,
   // multiplier request
   output logic [OPND_W-1:0]   mulreq_msg_a,
   output logic [OPND_W-1:0]   mulreq_msg_b,
   output logic                mulreq_val,
   input  logic                mulreq_rdy,
   // multiplier response
   input  logic [RESULT_W-1:0] mulresp_msg_result,
   input  logic                mulresp_val,
   output logic                mulresp_rdy,
   // tagged result
   output logic [RESULT_W-1:0] res_msg_result,
   output logic [TAG_W-1:0]    res_tag,
   output logic                res_val,
   input  logic                res_rdy,
   // watchdog
   output logic                timeout_err
);

   localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
   localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
   localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUT);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [TAG_W-1:0]    issue_tag_q,   issue_tag_d;
   logic [OUT_W-1:0]    outstanding_q, outstanding_d;
   logic [WD_W-1:0]     wd_cnt_q,      wd_cnt_d;
   logic                timeout_q,     timeout_d;
   logic                res_val_q,     res_val_d;
   logic [RESULT_W-1:0] res_result_q,  res_result_d;
   logic [TAG_W-1:0]    res_tag_q,     res_tag_d;

   // ---------------------------------------------------------------------
   // FIFOs
   // ---------------------------------------------------------------------
   cmd_msg_t         cmd_in;
   cmd_msg_t         cmd_head;
   logic             cmd_full;
   logic             cmd_empty;

   logic [TAG_W-1:0] tag_head;
   logic             tag_full;
   logic             tag_empty;

   logic             req_fire;
   logic             resp_fire;
   logic             res_fire;

   assign cmd_in.a = cmd_msg_a;
   assign cmd_in.b = cmd_msg_b;

   // The command is written on cmd fire; the queue itself refuses writes
   // while full, which is exactly cmd_rdy.
   imuldiv_queue #(
      .WIDTH (CMD_MSG_W),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_queue (
      .clk      (clk),
      .reset    (reset),
      .enq_val  (cmd_val),
      .enq_data (cmd_in),
      .full     (cmd_full),
      .deq_en   (req_fire),
      .deq_data (cmd_head),
      .empty    (cmd_empty)
   );

   // Tags of issued requests, in issue order; the multiplier answers in order,
   // so the head always belongs to the next response.
   imuldiv_queue #(
      .WIDTH (TAG_W),
      .DEPTH (MAX_OUT)
   ) u_tag_queue (
      .clk      (clk),
      .reset    (reset),
      .enq_val  (req_fire),
      .enq_data (issue_tag_q),
      .full     (tag_full),
      .deq_en   (resp_fire),
      .deq_data (tag_head),
      .empty    (tag_empty)
   );

   // ---------------------------------------------------------------------
   // Handshakes
   // ---------------------------------------------------------------------
   // The tag FIFO occupancy tracks outstanding exactly; qualifying with its
   // status as well guarantees it can never over- or under-flow.
   assign cmd_rdy      = !cmd_full;
   assign mulreq_val   = !cmd_empty && (outstanding_q < OUT_MAX) && !tag_full;
   assign mulreq_msg_a = cmd_head.a;
   assign mulreq_msg_b = cmd_head.b;
   assign mulresp_rdy  = (outstanding_q != '0) && !tag_empty
                         && (!res_val_q || res_rdy);

   assign req_fire  = mulreq_val && mulreq_rdy;
   assign resp_fire = mulresp_val && mulresp_rdy;
   assign res_fire  = res_val_q && res_rdy;

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      issue_tag_d   = issue_tag_q;
      outstanding_d = outstanding_q;
      wd_cnt_d      = wd_cnt_q;
      timeout_d     = timeout_q;
      res_val_d     = res_val_q;
      res_result_d  = res_result_q;
      res_tag_d     = res_tag_q;

      // Tag counter wraps naturally at 2^TAG_W.
      if (req_fire) issue_tag_d = issue_tag_q + TAG_W'(1);

      // Simultaneous issue and response cancel out.
      case ({req_fire, resp_fire})
         2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
         2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
         default: outstanding_d = outstanding_q;
      endcase

      // Result stage: a new response overrides the clear from res fire,
      // giving one result per cycle while the consumer keeps up.
      if (resp_fire) begin
         res_val_d    = 1'b1;
         res_result_d = mulresp_msg_result;
         res_tag_d    = tag_head;
      end else if (res_fire) begin
         res_val_d    = 1'b0;
      end

      // Watchdog only runs while something is outstanding and silent.
      if (resp_fire || (outstanding_q == '0)) begin
         wd_cnt_d = '0;
      end else if (wd_cnt_q != WD_LAST) begin
         wd_cnt_d = wd_cnt_q + WD_W'(1);
      end

      if (wd_cnt_q == WD_LAST) timeout_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         issue_tag_q   <= '0;
         outstanding_q <= '0;
         wd_cnt_q      <= '0;
         timeout_q     <= 1'b0;
         res_val_q     <= 1'b0;
         res_result_q  <= '0;
         res_tag_q     <= '0;
      end else begin
         issue_tag_q   <= issue_tag_d;
         outstanding_q <= outstanding_d;
         wd_cnt_q      <= wd_cnt_d;
         timeout_q     <= timeout_d;
         res_val_q     <= res_val_d;
         res_result_q  <= res_result_d;
         res_tag_q     <= res_tag_d;
      end
   end

   assign res_val        = res_val_q;
   assign res_msg_result = res_result_q;
   assign res_tag        = res_tag_q;
   assign timeout_err    = timeout_q;

endmodule : imuldiv_mul_requester
